duty_cycle_generator: RTL and testbench
=======================================

# duty_cycle_generator

Transmit-side counterpart of the duty-cycle measurement path. It takes an 8-bit duty value through a valid/ready handshake and drives a PWM waveform. The waveform is high for exactly `duty` cycles in each `PERIOD`-cycle frame. Frame length and encoding match the measurement block's 255-cycle window, so generator → measurement loopback returns the programmed value. It sits between the control logic that selects a duty setting and the output pin or ring line.

## Interface
Parameters:
- `WIDTH`, 8: width of duty value and frame counter.
- `PERIOD`, 255: frame length in clock cycles; counter runs 0..PERIOD-1; must be ≤ 2^WIDTH.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `enable`, input, 1: run/stop; low forces idle.
- `duty_in`, input, WIDTH: requested high-time in cycles per frame.
- `duty_valid`, input, 1: `duty_in` is offered.
- `duty_ready`, output, 1: pending buffer empty; the value is accepted on `duty_valid && duty_ready`.
- `pwm_out`, output, 1: registered PWM waveform.
- `period_start`, output, 1: one-cycle pulse marking the first cycle of each frame.
- `active_duty`, output, WIDTH: duty currently in effect, for readback.

## Operation
- Reset (`reset`=0 at an edge):
  - `pwm_out`=0, `period_start`=0, `duty_ready`=1, `active_duty`=0.
  - Frame counter = 0; pending buffer empty; state = IDLE.
  - Reset overrides all other inputs, including mid-frame.
- FSM states:
  - IDLE: counter held at 0; `pwm_out`=0; `period_start`=0.
  - RUN: counter increments each cycle and wraps PERIOD-1 → 0.
  - IDLE → RUN when `enable`=1. RUN → IDLE when `enable`=0.
- Leaving RUN mid-frame:
  - Counter returns to 0.
  - Next RUN entry starts a fresh frame at counter 0.
  - `active_duty` and the pending buffer are retained.
- Handshake and double buffering:
  - An accepted value goes into the pending buffer; `duty_ready` drops the next cycle.
  - The handshake is accepted in both IDLE and RUN.
  - The pending value transfers to `active_duty` only at a frame boundary, i.e. the cycle the counter is 0 in RUN, including the first RUN cycle after IDLE. The pending buffer then empties and `duty_ready` rises the following cycle.
  - If acceptance and a boundary occur in the same cycle, there is no bypass: the new value lands in pending and takes effect at the following boundary.
  - `duty_in` is ignored while `duty_ready`=0.
- Waveform:
  - In RUN, `pwm_out` next = (counter < `active_duty`), using the `active_duty` value after any same-cycle boundary update.
  - `active_duty`=0 gives a constant low output.
  - `active_duty` ≥ PERIOD saturates to constant high.
  - Comparison is unsigned, WIDTH bits. The counter never exceeds PERIOD-1.
- `period_start` next = 1 when in RUN with counter = 0.

## Timing
- All outputs are registered: one cycle of latency from the internal counter value to `pwm_out` and `period_start`.
- `enable` rising at edge k:
  - Counter = 0 during cycle k+1.
  - `period_start`=1 and the first high `pwm_out` cycle (if duty > 0) appear during cycle k+2.
- Frame repeats every PERIOD cycles; `period_start` pulses are exactly PERIOD cycles apart.
- High-time per frame is exactly `min(active_duty, PERIOD)` cycles, contiguous, starting on the `period_start` cycle.
- Latency from handshake to `active_duty` update: at most 2×PERIOD cycles, and at least one full frame boundary.
- `duty_ready` is low for at least 1 cycle after each acceptance.
- `enable` falling at edge k: `pwm_out`=0 and `period_start`=0 from cycle k+1.

## Structure
- Shared package (`duty_cycle_pkg`):
  - Constants `DUTY_WIDTH`=8 and `DUTY_PERIOD`=255, used by both the generator and the measurement block.
  - State encoding `IDLE`/`RUN`.
- Sub-module `pwm_period_counter`: WIDTH-bit counter with synchronous active-low clear, enable, and wrap at PERIOD-1. It outputs `count` and a `wrap` flag.
- The top level contains the FSM, the pending/active registers, the comparator and the output registers.

## Test plan
- Reset, load 128, enable → `active_duty`=128 at first boundary; each frame has 128 high then 127 low cycles; `period_start` every 255 cycles.
- Load 0, then 255 in separate frames → constant low for a full frame, then constant high for a full frame with no glitch at the wrap.
- Mid-frame load of 64 while running at 200 → current frame keeps 200 high; next frame 64 high; `duty_ready` low from acceptance until the cycle after the boundary.
- Offer 10 with `duty_valid` held while `duty_ready`=0, plus a second value → only the first accepted value is applied; the second is taken after ready rises.
- Drop `enable` at counter 100, raise it 5 cycles later → `pwm_out`=0 during the gap; the new frame restarts at count 0 with `period_start`; `active_duty` unchanged.
- Assert `reset` at counter 50 with pending non-empty → all outputs take reset values the next cycle and the pending value is discarded.
- Loopback to the measurement block with duty 77 → measured value 77 after one full window.

Source files
------------

// File: rtl/duty_cycle_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : duty_cycle_pkg
//  Purpose  : Constants and state encoding shared by the duty-cycle
//             generator and the duty-cycle measurement block. Both sides
//             must agree on frame length and duty width so that a
//             generator -> measurement loopback returns the programmed duty.
//  Contents : DUTY_WIDTH  - width of duty value and frame counter
//             DUTY_PERIOD - frame / measurement window length in cycles
//             state_t     - generator FSM encoding (IDLE / RUN)
//  Revision : 1.0 - initial release
// ============================================================================
package duty_cycle_pkg;

    localparam int DUTY_WIDTH  = 8;
    localparam int DUTY_PERIOD = 255;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : duty_cycle_pkg
`default_nettype wire

// File: rtl/duty_cycle_generator_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pwm_period_counter
//  Purpose  : Frame counter for the PWM generator. Counts 0..PERIOD-1 while
//             enabled and wraps back to 0. A synchronous active-low clear
//             has priority over counting.
//  Ports    : clk       - clock, rising edge
//             i_clear_n - synchronous clear, active low
//             i_en      - count enable
//             o_count   - current count
//             o_wrap    - high when the next enabled edge wraps to 0
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_period_counter
    import duty_cycle_pkg::*;
#(
    parameter int WIDTH  = DUTY_WIDTH,
    parameter int PERIOD = DUTY_PERIOD
) (
    input  logic             clk,
    input  logic             i_clear_n,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] c_LAST_COUNT = WIDTH'(PERIOD - 1);

    logic [WIDTH-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == c_LAST_COUNT);

    always_ff @(posedge clk) begin
        if (!i_clear_n) begin
            r_count <= '0;
        end else if (i_en) begin
            if (w_at_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count = r_count;
    assign o_wrap  = i_en && w_at_last;

endmodule : pwm_period_counter
`default_nettype wire

// File: rtl/duty_cycle_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : duty_cycle_generator
//  Purpose  : PWM transmitter. Accepts a duty value over a valid/ready
//             handshake into a pending buffer, promotes it to the active
//             duty at a frame boundary, and drives a waveform that is high
//             for exactly min(active_duty, PERIOD) cycles per frame.
//  Ports    : clk            - clock, rising edge
//             i_reset        - synchronous reset, active low
//             i_enable       - run (1) / stop (0)
//             i_duty_in      - requested high time per frame
//             i_duty_valid   - i_duty_in is offered
//             o_duty_ready   - pending buffer empty, offer will be taken
//             o_pwm_out      - registered PWM waveform
//             o_period_start - one-cycle pulse on the first cycle of a frame
//             o_active_duty  - duty currently in effect
//  Revision : 1.0 - initial release
// ============================================================================
module duty_cycle_generator
    import duty_cycle_pkg::*;
#(
    parameter int WIDTH  = DUTY_WIDTH,
    parameter int PERIOD = DUTY_PERIOD
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_duty_in,
    input  logic             i_duty_valid,
    output logic             o_duty_ready,
    output logic             o_pwm_out,
    output logic             o_period_start,
    output logic [WIDTH-1:0] o_active_duty
);

    state_t           r_state;
    logic [WIDTH-1:0] r_pend;
    logic             r_pend_valid;
    logic [WIDTH-1:0] r_active;
    logic             r_pwm;
    logic             r_period_start;
    logic             r_cnt_zero;

    logic [WIDTH-1:0] w_count;
    logic             w_wrap;
    logic             w_clear_n;
    logic             w_running;
    logic             w_boundary;
    logic             w_promote;
    logic             w_accept;
    logic [WIDTH-1:0] w_active_next;

    // The counter is held at 0 outside RUN; dropping enable mid-frame
    // clears it so the next RUN entry begins a fresh frame.
    assign w_clear_n  = i_reset && i_enable;
    assign w_running  = (r_state == RUN) && i_enable;

    pwm_period_counter #(
        .WIDTH  (WIDTH),
        .PERIOD (PERIOD)
    ) u_counter (
        .clk       (clk),
        .i_clear_n (w_clear_n),
        .i_en      (w_running),
        .o_count   (w_count),
        .o_wrap    (w_wrap)
    );

    // r_cnt_zero mirrors (w_count == 0) as a flop, derived from the
    // counter's clear/wrap behaviour, so the boundary decode is one bit.
    assign w_boundary    = w_running && r_cnt_zero;
    assign w_promote     = w_boundary && r_pend_valid;
    // Acceptance needs an empty buffer and promotion needs a full one, so
    // the two never coincide: a value accepted on a boundary waits a frame.
    assign w_accept      = i_duty_valid && !r_pend_valid;
    assign w_active_next = w_promote ? r_pend : r_active;

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            r_state        <= IDLE;
            r_pend         <= '0;
            r_pend_valid   <= 1'b0;
            r_active       <= '0;
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
            r_cnt_zero     <= 1'b1;
        end else begin
            // FSM
            if (r_state == IDLE) begin
                if (i_enable) begin
                    r_state <= RUN;
                end
            end else begin
                if (!i_enable) begin
                    r_state <= IDLE;
                end
            end

            // Pending / active double buffer
            r_active <= w_active_next;
            if (w_promote) begin
                r_pend_valid <= 1'b0;
            end else if (w_accept) begin
                r_pend       <= i_duty_in;
                r_pend_valid <= 1'b1;
            end

            // Counter-is-zero tracker
            if (!i_enable) begin
                r_cnt_zero <= 1'b1;
            end else if (r_state == RUN) begin
                r_cnt_zero <= w_wrap;
            end

            // Waveform outputs. Since the counter never exceeds PERIOD-1,
            // any active duty >= PERIOD yields a constant high output.
            if (w_running) begin
                r_pwm          <= (w_count < w_active_next);
                r_period_start <= r_cnt_zero;
            end else begin
                r_pwm          <= 1'b0;
                r_period_start <= 1'b0;
            end
        end
    end

    assign o_duty_ready   = !r_pend_valid;
    assign o_pwm_out      = r_pwm;
    assign o_period_start = r_period_start;
    assign o_active_duty  = r_active;

endmodule : duty_cycle_generator
`default_nettype wire

// File: tb/tb_duty_cycle_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_duty_cycle_generator
//  Purpose  : Self-checking bench for duty_cycle_generator. Stimulus pushes
//             the expected duty of each frame it wants checked; a monitor
//             measures every complete frame (high time, shape, active duty,
//             spacing to the next frame start) and compares against the queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_duty_cycle_generator;
    import duty_cycle_pkg::*;

    localparam int W = DUTY_WIDTH;
    localparam int P = DUTY_PERIOD;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         valid;
    logic [W-1:0] din;
    logic         ready;
    logic         pwm;
    logic         ps;
    logic [W-1:0] active;

    always #5 clk = ~clk;

    duty_cycle_generator #(.WIDTH(W), .PERIOD(P)) dut (
        .clk            (clk),
        .i_reset        (rst_n),
        .i_enable       (en),
        .i_duty_in      (din),
        .i_duty_valid   (valid),
        .o_duty_ready   (ready),
        .o_pwm_out      (pwm),
        .o_period_start (ps),
        .o_active_duty  (active)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int sb_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit         in_frame   = 1'b0;
    bit         want_start = 1'b0;
    int         fcnt       = 0;
    int         fact       = 0;
    logic [P-1:0] bits;

    always @(negedge clk) begin
        if (!rst_n || !en) begin
            in_frame   = 1'b0;
            want_start = 1'b0;
        end else begin
            if (want_start) begin
                check("frame_spacing", int'(ps), 1);
                want_start = 1'b0;
            end
            if (ps) begin
                check("no_early_start", int'(in_frame), 0);
                in_frame = 1'b1;
                fcnt     = 0;
                fact     = int'(active);
            end
            if (in_frame) begin
                bits[fcnt] = pwm;
                fcnt++;
                if (fcnt == P) begin
                    in_frame   = 1'b0;
                    want_start = 1'b1;
                    if (sb_q.size() > 0) begin
                        int e;
                        int hi;
                        int mism;
                        e    = sb_q.pop_front();
                        hi   = 0;
                        mism = 0;
                        for (int i = 0; i < P; i++) begin
                            if (bits[i]) hi++;
                            if (bits[i] != (i < e)) mism++;
                        end
                        check("frame_high_cycles", hi, (e < P) ? e : P);
                        check("frame_shape_errors", mism, 0);
                        check("frame_active_duty", fact, e);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_start(input int exp, input bit push);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * P + 10; i++) begin
            @(negedge clk);
            if (ps) begin
                found = 1'b1;
                if (push) sb_q.push_back(exp);
                break;
            end
        end
        if (!found) check("period_start_timeout", 0, 1);
    endtask

    task automatic send(input int d);
        bit found;
        found = 1'b0;
        valid = 1'b1;
        din   = W'(d);
        for (int i = 0; i < 3 * P; i++) begin
            if (ready) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            check("handshake_timeout", 0, 1);
            valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            valid = 1'b0;
            check("ready_drop_after_accept", int'(ready), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        bit held;
        bit found;
        rst_n = 1'b0;
        en    = 1'b0;
        valid = 1'b0;
        din   = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", int'(ready), 1);
        check("reset_pwm", int'(pwm), 0);
        check("reset_period_start", int'(ps), 0);
        check("reset_active", int'(active), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Load 128 while idle: buffered, not yet active
        send(128);
        check("idle_active_unchanged", int'(active), 0);
        check("idle_pwm_low", int'(pwm), 0);

        // Enable: counter 0 next cycle, period_start one cycle later
        en = 1'b1;
        @(negedge clk);
        check("enable_start_latency_k1", int'(ps), 0);
        @(negedge clk);
        check("enable_start_latency_k2", int'(ps), 1);
        check("first_boundary_active", int'(active), 128);
        check("first_cycle_pwm", int'(pwm), 1);
        check("ready_after_boundary", int'(ready), 1);
        sb_q.push_back(128);
        wait_start(128, 1'b1);

        // 0 then 255, including two back-to-back 255 frames across a wrap
        send(0);
        wait_start(0, 1'b1);
        send(255);
        wait_start(255, 1'b1);
        wait_start(255, 1'b1);

        // Mid-frame load of 64 while running at 200
        send(200);
        wait_start(200, 1'b1);
        repeat (30) @(negedge clk);
        send(64);
        held  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            if (ps) begin
                found = 1'b1;
                break;
            end
            if (ready) held = 1'b0;
        end
        check("ready_low_until_boundary", int'(held && found), 1);
        check("ready_high_after_boundary", int'(ready), 1);
        sb_q.push_back(64);

        // Offers while ready is low are ignored; 99 is taken once ready rises
        send(10);
        valid = 1'b1;
        din   = W'(33);
        repeat (20) @(negedge clk);
        fork
            send(99);
            wait_start(10, 1'b1);
        join
        wait_start(99, 1'b1);

        // Drop enable near count 100 for 5 cycles
        wait_start(99, 1'b0);
        repeat (99) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("disabled_outputs_low", int'({pwm, ps}), 0);
        end
        en = 1'b1;
        @(negedge clk);
        check("restart_latency_k1", int'(ps), 0);
        @(negedge clk);
        check("restart_period_start", int'(ps), 1);
        check("restart_active_kept", int'(active), 99);
        sb_q.push_back(99);

        // Reset mid-frame with a pending value
        wait_start(99, 1'b0);
        send(50);
        repeat (47) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midframe_reset_pwm", int'(pwm), 0);
        check("midframe_reset_period_start", int'(ps), 0);
        check("midframe_reset_ready", int'(ready), 1);
        check("midframe_reset_active", int'(active), 0);
        rst_n = 1'b1;
        wait_start(0, 1'b1);

        // Loopback-style measurement of 77
        send(77);
        wait_start(77, 1'b1);
        wait_start(77, 1'b0);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_duty_cycle_generator
`default_nettype wire
